// File: rtl/modbus_rx_frame_ctrl.sv
// modbus_rx_frame_ctrl: Modbus RTU frame delimiting, address filter, length bound and CRC16 check (CRC built only with MODBUS_RX_CRC_CHECK_EN)
module modbus_rx_frame_ctrl #(
  parameter int T35_CYCLES = 100260,
  parameter logic [7:0] SLAVE_ADDR = 8'd2,
  parameter int MAX_LEN = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] frame_byte,
  output logic       frame_wr,
  output logic [5:0] frame_idx,
  output logic [5:0] frame_len,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(T35_CYCLES + 1);
  localparam logic [CW-1:0] T35 = CW'(T35_CYCLES);
  localparam logic [5:0] ML = 6'(MAX_LEN);
  typedef enum logic [1:0] {SYNC, IDLE, RECV, DISCARD} state_t;
  state_t state;
  logic [CW-1:0] sil;
  logic [5:0] count;
  logic expire;
  assign expire = !rx_valid && (sil == T35 - 1'b1);
`ifdef MODBUS_RX_CRC_CHECK_EN
  logic [15:0] crc;
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'hA001 : r >> 1;
    return r;
  endfunction
  // running residual; the low byte of the frame CRC arrives first so a good frame folds to zero
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= 16'hFFFF;
    else if (rx_valid && (state == IDLE || (state == RECV && count < ML)))
      crc <= crc_upd(state == IDLE ? 16'hFFFF : crc, rx_byte);
`endif
  // line silence counter; a byte in the expire cycle restarts it and suppresses expire
  always_ff @(posedge clk or posedge rst)
    if (rst) sil <= '0;
    else sil <= rx_valid ? '0 : (sil == T35 ? sil : sil + 1'b1);
  // frame state machine with registered strobes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SYNC;
      count <= '0;
      frame_byte <= '0;
      frame_wr <= 1'b0;
      frame_idx <= '0;
      frame_len <= '0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      frame_wr <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        SYNC: if (expire) state <= IDLE;
        IDLE:
          if (rx_valid) begin
            if (rx_byte == SLAVE_ADDR) begin
              state <= RECV;
              busy <= 1'b1;
              frame_wr <= 1'b1;
              frame_byte <= rx_byte;
              frame_idx <= '0;
              count <= 6'd1;
            end else state <= DISCARD;
          end
        RECV:
          if (rx_valid) begin
            if (count < ML) begin
              frame_wr <= 1'b1;
              frame_byte <= rx_byte;
              frame_idx <= count;
              count <= count + 6'd1;
            end else begin
              state <= DISCARD;
              busy <= 1'b0;
              frame_err <= 1'b1;
              frame_len <= ML;
            end
          end else if (expire) begin
            state <= IDLE;
            busy <= 1'b0;
            frame_len <= count;
`ifdef MODBUS_RX_CRC_CHECK_EN
            frame_done <= count >= 6'd4 && crc == 16'h0000;
            frame_err <= count < 6'd4 || crc != 16'h0000;
`else
            frame_done <= count >= 6'd4;
            frame_err <= count < 6'd4;
`endif
          end
        DISCARD: if (expire) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_modbus_rx_frame_ctrl.sv
// tb_modbus_rx_frame_ctrl: directed bench for the Modbus RTU frame controller
module tb_modbus_rx_frame_ctrl;
  localparam int T35 = 40;
  logic clk, rst, rx_valid, frame_wr, frame_done, frame_err, busy;
  logic [7:0] rx_byte, frame_byte;
  logic [5:0] frame_idx, frame_len;
  int checks = 0, errors = 0;
  int wr_n = 0, done_n = 0, err_n = 0, both_n = 0;
  logic [7:0] wr_byte [64];
  logic [5:0] wr_idx [64];
  logic [5:0] last_len;
  logic [7:0] fb [32];
  int cyc;

  modbus_rx_frame_ctrl #(.T35_CYCLES(T35), .SLAVE_ADDR(8'd1), .MAX_LEN(25)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_byte(frame_byte), .frame_wr(frame_wr), .frame_idx(frame_idx),
    .frame_len(frame_len), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every strobe seen on the falling edge
  always @(negedge clk) begin
    if (frame_wr && wr_n < 64) begin
      wr_byte[wr_n] = frame_byte;
      wr_idx[wr_n] = frame_idx;
      wr_n++;
    end
    if (frame_done) begin done_n++; last_len = frame_len; end
    if (frame_err) begin err_n++; last_len = frame_len; end
    if (frame_done && frame_err) both_n++;
  end

  task automatic clear_log();
    wr_n = 0; done_n = 0; err_n = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_buf(input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat (2) @(negedge clk);
      send_byte(fb[i]);
    end
  endtask

  task automatic silence();
    repeat (T35 + 5) @(negedge clk);
  endtask

  task automatic wait_pulse(output int c);
    c = 0;
    while (!(frame_done || frame_err) && c < 2 * T35) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic load_good(input logic [7:0] last);
    fb[0] = 8'h01; fb[1] = 8'h03; fb[2] = 8'h00; fb[3] = 8'h00;
    fb[4] = 8'h00; fb[5] = 8'h01; fb[6] = 8'h84; fb[7] = last;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_byte, frame_wr, frame_idx, frame_len, frame_done, frame_err, busy} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got byte=%h wr=%b idx=%0d len=%0d done=%b err=%b busy=%b want all 0",
               frame_byte, frame_wr, frame_idx, frame_len, frame_done, frame_err, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_sync();
    clear_log();
    load_good(8'h0A);
    send_buf(8);
    silence();
    checks++;
    if (wr_n !== 0) begin errors++; $display("FAIL sync_writes got %0d want 0", wr_n); end
    checks++;
    if (done_n + err_n !== 0) begin errors++; $display("FAIL sync_pulses got %0d want 0", done_n + err_n); end
  endtask

  task automatic test_good(input string tag);
    clear_log();
    load_good(8'h0A);
    send_byte(fb[0]);
    checks++;
    if ({frame_wr, frame_idx, frame_byte, busy} !== {1'b1, 6'd0, 8'h01, 1'b1}) begin
      errors++;
      $display("FAIL %s_first_write got wr=%b idx=%0d byte=%h busy=%b want 1 0 01 1", tag, frame_wr, frame_idx, frame_byte, busy);
    end
    for (int i = 1; i < 8; i++) begin
      repeat (2) @(negedge clk);
      send_byte(fb[i]);
    end
    wait_pulse(cyc);
    checks++;
    if (cyc !== T35) begin errors++; $display("FAIL %s_done_latency got %0d want %0d", tag, cyc, T35); end
    checks++;
    if ({frame_done, frame_err, frame_len, busy} !== {1'b1, 1'b0, 6'd8, 1'b0}) begin
      errors++;
      $display("FAIL %s_pulse got done=%b err=%b len=%0d busy=%b want 1 0 8 0", tag, frame_done, frame_err, frame_len, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n !== 8) begin errors++; $display("FAIL %s_write_count got %0d want 8", tag, wr_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_idx[i] !== 6'(i) || wr_byte[i] !== fb[i]) begin
        errors++;
        $display("FAIL %s_write%0d got idx=%0d byte=%h want idx=%0d byte=%h", tag, i, wr_idx[i], wr_byte[i], i, fb[i]);
      end
    end
    checks++;
    if (done_n !== 1 || err_n !== 0) begin errors++; $display("FAIL %s_pulse_count got done=%0d err=%0d want 1 0", tag, done_n, err_n); end
  endtask

  task automatic test_bad_crc();
    clear_log();
    load_good(8'h0B);
    send_buf(8);
    silence();
    checks++;
    if (wr_n !== 8) begin errors++; $display("FAIL badcrc_writes got %0d want 8", wr_n); end
`ifdef MODBUS_RX_CRC_CHECK_EN
    checks++;
    if (done_n !== 0 || err_n !== 1) begin errors++; $display("FAIL badcrc_pulses got done=%0d err=%0d want 0 1", done_n, err_n); end
`else
    checks++;
    if (done_n !== 1 || err_n !== 0) begin errors++; $display("FAIL badcrc_pulses got done=%0d err=%0d want 1 0", done_n, err_n); end
`endif
    checks++;
    if (last_len !== 6'd8) begin errors++; $display("FAIL badcrc_len got %0d want 8", last_len); end
  endtask

  task automatic test_addr();
    clear_log();
    load_good(8'h0A);
    fb[0] = 8'h05;
    send_buf(8);
    silence();
    checks++;
    if (wr_n + done_n + err_n !== 0) begin
      errors++;
      $display("FAIL addr_filter got wr=%0d done=%0d err=%0d want 0 0 0", wr_n, done_n, err_n);
    end
    test_good("after_addr");
  endtask

  task automatic test_short();
    clear_log();
    fb[0] = 8'h01; fb[1] = 8'h03; fb[2] = 8'h00;
    send_buf(3);
    silence();
    checks++;
    if (done_n !== 0 || err_n !== 1 || last_len !== 6'd3) begin
      errors++;
      $display("FAIL short_frame got done=%0d err=%0d len=%0d want 0 1 3", done_n, err_n, last_len);
    end
  endtask

  task automatic test_overflow();
    clear_log();
    fb[0] = 8'h01;
    for (int i = 1; i < 26; i++) fb[i] = 8'(8'h40 + i);
    send_buf(25);
    repeat (2) @(negedge clk);
    send_byte(fb[25]);
    checks++;
    if (frame_err !== 1'b1 || frame_done !== 1'b0 || frame_len !== 6'd25) begin
      errors++;
      $display("FAIL overflow_pulse got err=%b done=%b len=%0d want 1 0 25", frame_err, frame_done, frame_len);
    end
    silence();
    checks++;
    if (wr_n !== 25) begin errors++; $display("FAIL overflow_writes got %0d want 25", wr_n); end
    checks++;
    if (wr_idx[24] !== 6'd24 || wr_byte[24] !== fb[24]) begin
      errors++;
      $display("FAIL overflow_last_write got idx=%0d byte=%h want 24 %h", wr_idx[24], wr_byte[24], fb[24]);
    end
    checks++;
    if (err_n !== 1 || done_n !== 0) begin errors++; $display("FAIL overflow_counts got err=%0d done=%0d want 1 0", err_n, done_n); end
    test_good("after_overflow");
  endtask

  task automatic test_rst_mid();
    clear_log();
    load_good(8'h0A);
    send_buf(3);
    rst = 1'b1;
    #1;
    checks++;
    if ({frame_wr, frame_idx, frame_len, busy, frame_done, frame_err} !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got wr=%b idx=%0d len=%0d busy=%b done=%b err=%b want all 0",
               frame_wr, frame_idx, frame_len, busy, frame_done, frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
    silence();
    checks++;
    if (done_n + err_n !== 0) begin errors++; $display("FAIL rst_mid_pulses got %0d want 0", done_n + err_n); end
    test_good("after_rst");
  endtask

  initial begin
    test_reset();
    test_sync();
    test_good("good");
    test_bad_crc();
    test_addr();
    test_short();
    test_overflow();
    test_rst_mid();
    checks++;
    if (both_n !== 0) begin errors++; $display("FAIL done_err_overlap got %0d want 0", both_n); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
